// File: rtl/interboard_pkg.sv
// Shared definitions for the board-to-board link (RX deframer and TX framer).
// Optional feature macro: INTERBOARD_CHECKSUM_EN adds a fifth XOR checksum word to each frame.
package interboard_pkg;

  localparam int IB_WORD_W = 6;

`ifdef INTERBOARD_CHECKSUM_EN
  localparam int IB_NUM_WORDS = 5;
`else
  localparam int IB_NUM_WORDS = 4;
`endif

  // Word index must be able to hold IB_NUM_WORDS itself (value seen in DELIVER).
  localparam int IB_IDX_W = 3;

  // Message type codes carried in W0.
  localparam logic [3:0] MSG_NOP    = 4'h0;
  localparam logic [3:0] MSG_MOVE   = 4'h1;
  localparam logic [3:0] MSG_SELECT = 4'h2;
  localparam logic [3:0] MSG_PLACE  = 4'h3;
  localparam logic [3:0] MSG_CARD   = 4'h4;
  localparam logic [3:0] MSG_RST    = 4'hF;

  // Field positions inside the frame words.
  // W0 = {msg_type[3:0], move_dir, 1'b0}
  // W1 = {block_x[4:0], 1'b0}
  // W2 = {block_y[2:0], sel_len[2:0]}
  // W3 = card[5:0]
  localparam int IB_W0_MSG_LSB = 2;
  localparam int IB_W0_DIR_BIT = 1;
  localparam int IB_W1_X_LSB   = 1;
  localparam int IB_W2_Y_LSB   = 3;
  localparam int IB_W2_SEL_LSB = 0;
  localparam int IB_W3_CARD_LSB = 0;

  // Receive FSM encoding.
  typedef enum logic [2:0] {
    IB_ST_ARM      = 3'd0,
    IB_ST_IDLE     = 3'd1,
    IB_ST_LATCH    = 3'd2,
    IB_ST_WAIT_LOW = 3'd3,
    IB_ST_DELIVER  = 3'd4
  } ib_rx_state_e;

  // Integrity word appended when the checksum feature is built in.
  function automatic logic [IB_WORD_W-1:0] ib_checksum(
    input logic [IB_WORD_W-1:0] w0,
    input logic [IB_WORD_W-1:0] w1,
    input logic [IB_WORD_W-1:0] w2,
    input logic [IB_WORD_W-1:0] w3
  );
    return w0 ^ w1 ^ w2 ^ w3;
  endfunction

endpackage

// File: rtl/interboard_sync.sv
// Multi-stage level synchronizer for a single asynchronous handshake line.
// RST_VAL lets the user choose the value the chain shows while coming out of reset.
module interboard_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous level through the metastability chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/interboard_rx_deframer.sv
// Receive side of the board-to-board link: 4-phase Request/Ack word handshake,
// frame reassembly and field decode with one-cycle delivery pulses.
// Optional feature macro: INTERBOARD_CHECKSUM_EN (5-word frame with XOR check word).
module interboard_rx_deframer
  import interboard_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       interboard_en,
  output logic       interboard_rst,
  output logic [3:0] interboard_msg_type,
  output logic       interboard_move_dir,
  output logic [4:0] interboard_block_x,
  output logic [2:0] interboard_block_y,
  output logic [2:0] interboard_sel_len,
  output logic [5:0] interboard_card,
  output logic       rx_busy,
  output logic       rx_err
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]    TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [IB_IDX_W-1:0] IDX_LAST = IB_IDX_W'(IB_NUM_WORDS - 1);

  ib_rx_state_e state_r, state_nx;

  logic                 req_s;
  logic                 req_d_r;
  logic [TMO_W-1:0]     tmo_cnt_r;
  logic [IB_IDX_W-1:0]  idx_r, idx_nx;
  logic [IB_WORD_W-1:0] slot_r [IB_NUM_WORDS];
  logic                 slot_we_s;
  logic                 fields_we_s;
  logic                 csum_ok_s;

  logic ack_r, ack_nx;
  logic en_r, en_nx;
  logic rst_pulse_r, rst_pulse_nx;
  logic err_r, err_nx;
  logic busy_r, busy_nx;

  logic [3:0] msg_type_r;
  logic       move_dir_r;
  logic [4:0] block_x_r;
  logic [2:0] block_y_r;
  logic [2:0] sel_len_r;
  logic [5:0] card_r;

  // Padding bits of W0/W1 carry no information.
  logic unused_pad_s;
  assign unused_pad_s = slot_r[0][0] ^ slot_r[1][0];

  // Request_in synchronizer; preset high so ARM waits for a genuinely low Request.
  interboard_sync #(
    .STAGES  (SYNC_N),
    .RST_VAL (1'b1)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (Request_in),
    .q   (req_s)
  );

`ifdef INTERBOARD_CHECKSUM_EN
  assign csum_ok_s = (ib_checksum(slot_r[0], slot_r[1], slot_r[2], slot_r[3]) == slot_r[4]);
`else
  assign csum_ok_s = 1'b1;
`endif

  // Idle-gap counter: cleared on every req_s edge, saturating at TIMEOUT_CYCLES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_d_r   <= 1'b1;
      tmo_cnt_r <= '0;
    end else begin
      req_d_r <= req_s;
      if (req_s != req_d_r) begin
        tmo_cnt_r <= '0;
      end else if (tmo_cnt_r != TMO_MAX) begin
        tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
    end
  end

  // Next-state, word index, handshake and pulse decisions.
  always_comb begin
    state_nx     = state_r;
    idx_nx       = idx_r;
    ack_nx       = ack_r;
    en_nx        = 1'b0;
    rst_pulse_nx = 1'b0;
    err_nx       = 1'b0;
    slot_we_s    = 1'b0;
    fields_we_s  = 1'b0;
    case (state_r)
      IB_ST_ARM: begin
        if (!req_s) begin
          state_nx = IB_ST_IDLE;
        end else begin
          state_nx = IB_ST_ARM;
        end
      end
      IB_ST_IDLE: begin
        // A new word wins over a coincident timeout.
        if (req_s) begin
          state_nx = IB_ST_LATCH;
        end else if ((idx_r != {IB_IDX_W{1'b0}}) && (tmo_cnt_r == TMO_MAX)) begin
          err_nx = 1'b1;
          idx_nx = {IB_IDX_W{1'b0}};
        end else begin
          state_nx = IB_ST_IDLE;
        end
      end
      IB_ST_LATCH: begin
        slot_we_s = 1'b1;
        ack_nx    = 1'b1;
        state_nx  = IB_ST_WAIT_LOW;
      end
      IB_ST_WAIT_LOW: begin
        if (!req_s) begin
          ack_nx = 1'b0;
          idx_nx = idx_r + {{(IB_IDX_W-1){1'b0}}, 1'b1};
          if (idx_r == IDX_LAST) begin
            state_nx = IB_ST_DELIVER;
          end else begin
            state_nx = IB_ST_IDLE;
          end
        end else begin
          state_nx = IB_ST_WAIT_LOW;
        end
      end
      IB_ST_DELIVER: begin
        idx_nx   = {IB_IDX_W{1'b0}};
        state_nx = IB_ST_IDLE;
        if (csum_ok_s) begin
          fields_we_s = 1'b1;
          if (slot_r[0][IB_W0_MSG_LSB +: 4] == MSG_RST) begin
            rst_pulse_nx = 1'b1;
          end else begin
            en_nx = 1'b1;
          end
        end else begin
          err_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IB_ST_ARM;
        idx_nx   = {IB_IDX_W{1'b0}};
        ack_nx   = 1'b0;
      end
    endcase
    busy_nx = (idx_nx != {IB_IDX_W{1'b0}}) ||
              (state_nx == IB_ST_LATCH) ||
              (state_nx == IB_ST_WAIT_LOW) ||
              (state_nx == IB_ST_DELIVER);
  end

  // FSM state, handshake and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IB_ST_ARM;
      idx_r       <= {IB_IDX_W{1'b0}};
      ack_r       <= 1'b0;
      en_r        <= 1'b0;
      rst_pulse_r <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      idx_r       <= idx_nx;
      ack_r       <= ack_nx;
      en_r        <= en_nx;
      rst_pulse_r <= rst_pulse_nx;
      err_r       <= err_nx;
      busy_r      <= busy_nx;
    end
  end

  // Word slots; data is sampled only in LATCH, when the peer holds it stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IB_NUM_WORDS; i++) begin
        slot_r[i] <= {IB_WORD_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < IB_NUM_WORDS; i++) begin
        if (slot_we_s && (idx_r == IB_IDX_W'(i))) begin
          slot_r[i] <= inter_data_in;
        end else begin
          slot_r[i] <= slot_r[i];
        end
      end
    end
  end

  // Decoded fields, updated only on an accepted frame and held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_type_r <= 4'h0;
      move_dir_r <= 1'b0;
      block_x_r  <= 5'h00;
      block_y_r  <= 3'h0;
      sel_len_r  <= 3'h0;
      card_r     <= 6'h00;
    end else if (fields_we_s) begin
      msg_type_r <= slot_r[0][IB_W0_MSG_LSB +: 4];
      move_dir_r <= slot_r[0][IB_W0_DIR_BIT];
      block_x_r  <= slot_r[1][IB_W1_X_LSB +: 5];
      block_y_r  <= slot_r[2][IB_W2_Y_LSB +: 3];
      sel_len_r  <= slot_r[2][IB_W2_SEL_LSB +: 3];
      card_r     <= slot_r[3][IB_W3_CARD_LSB +: 6];
    end else begin
      msg_type_r <= msg_type_r;
      move_dir_r <= move_dir_r;
      block_x_r  <= block_x_r;
      block_y_r  <= block_y_r;
      sel_len_r  <= sel_len_r;
      card_r     <= card_r;
    end
  end

  assign Ack_out             = ack_r;
  assign interboard_en       = en_r;
  assign interboard_rst      = rst_pulse_r;
  assign interboard_msg_type = msg_type_r;
  assign interboard_move_dir = move_dir_r;
  assign interboard_block_x  = block_x_r;
  assign interboard_block_y  = block_y_r;
  assign interboard_sel_len  = sel_len_r;
  assign interboard_card     = card_r;
  assign rx_busy             = busy_r;
  assign rx_err              = err_r;

endmodule

// File: tb/tb_interboard_rx_deframer.sv
// Directed self-checking bench for interboard_rx_deframer.
module tb_interboard_rx_deframer;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       Request_in;
  logic [5:0] inter_data_in;
  logic       Ack_out;
  logic       interboard_en;
  logic       interboard_rst;
  logic [3:0] interboard_msg_type;
  logic       interboard_move_dir;
  logic [4:0] interboard_block_x;
  logic [2:0] interboard_block_y;
  logic [2:0] interboard_sel_len;
  logic [5:0] interboard_card;
  logic       rx_busy;
  logic       rx_err;

  int n_asserts = 0;
  int n_fails   = 0;
  int en_cnt = 0, rst_cnt = 0, err_cnt = 0, both_cnt = 0;

  always #5 clk = ~clk;

  interboard_rx_deframer #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Request_in          (Request_in),
    .inter_data_in       (inter_data_in),
    .Ack_out             (Ack_out),
    .interboard_en       (interboard_en),
    .interboard_rst      (interboard_rst),
    .interboard_msg_type (interboard_msg_type),
    .interboard_move_dir (interboard_move_dir),
    .interboard_block_x  (interboard_block_x),
    .interboard_block_y  (interboard_block_y),
    .interboard_sel_len  (interboard_sel_len),
    .interboard_card     (interboard_card),
    .rx_busy             (rx_busy),
    .rx_err              (rx_err)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (interboard_en) en_cnt++;
    if (interboard_rst) rst_cnt++;
    if (rx_err) err_cnt++;
    if (interboard_en && interboard_rst) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input logic [3:0] m, input logic d, input logic [4:0] x,
                            input logic [2:0] y, input logic [2:0] s, input logic [5:0] c);
    chk("msg_type", {28'h0, interboard_msg_type}, {28'h0, m});
    chk("move_dir", {31'h0, interboard_move_dir}, {31'h0, d});
    chk("block_x",  {27'h0, interboard_block_x},  {27'h0, x});
    chk("block_y",  {29'h0, interboard_block_y},  {29'h0, y});
    chk("sel_len",  {29'h0, interboard_sel_len},  {29'h0, s});
    chk("card",     {26'h0, interboard_card},     {26'h0, c});
  endtask

  // One 4-phase handshake; hold = extra cycles Request stays high after Ack.
  task automatic send_word(input logic [5:0] w, input int hold);
    bit got;
    inter_data_in = w;
    Request_in    = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (Ack_out) got = 1'b1;
    end
    chk("ack_rise", {31'h0, got}, 32'h1);
    inter_data_in = ~w;
    repeat (hold) @(negedge clk);
    Request_in = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!Ack_out) got = 1'b1;
    end
    chk("ack_fall", {31'h0, got}, 32'h1);
  endtask

  task automatic send_frame(input logic [3:0] m, input logic d, input logic [4:0] x,
                            input logic [2:0] y, input logic [2:0] s, input logic [5:0] c,
                            input int hold1);
    logic [5:0] w0, w1, w2, w3;
    w0 = {m, d, 1'b0};
    w1 = {x, 1'b0};
    w2 = {y, s};
    w3 = c;
    send_word(w0, 0);
    send_word(w1, hold1);
    send_word(w2, 0);
    send_word(w3, 0);
`ifdef INTERBOARD_CHECKSUM_EN
    send_word(w0 ^ w1 ^ w2 ^ w3, 0);
`endif
  endtask

  initial begin
    int en0, rst0, err0;
    bit seen;
    rst           = 1'b0;
    Request_in    = 1'b1;
    inter_data_in = 6'h00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ack",  {31'h0, Ack_out}, 32'h0);
    chk("rst_en",   {31'h0, interboard_en}, 32'h0);
    chk("rst_rstp", {31'h0, interboard_rst}, 32'h0);
    chk("rst_busy", {31'h0, rx_busy}, 32'h0);
    chk("rst_err",  {31'h0, rx_err}, 32'h0);
    chk_fields(4'h0, 1'b0, 5'h00, 3'h0, 3'h0, 6'h00);

    // Test 1: Request held high across reset release must not be acknowledged
    rst  = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (Ack_out) seen = 1'b1;
    end
    chk("arm_no_ack", {31'h0, seen}, 32'h0);
    chk("arm_busy",   {31'h0, rx_busy}, 32'h0);
    Request_in = 1'b0;
    repeat (5) @(negedge clk);
    en0 = en_cnt;
    send_frame(4'h1, 1'b0, 5'd3, 3'd2, 3'd1, 6'h07, 0);
    repeat (3) @(negedge clk);
    chk("t1_en_cnt", en_cnt - en0, 32'd1);
    chk_fields(4'h1, 1'b0, 5'd3, 3'd2, 3'd1, 6'h07);

    // Test 2: W0=0x0E W1=0x22 W2=0x2C W3=0x2A, exact delivery cycle
    en0 = en_cnt; rst0 = rst_cnt;
    send_frame(4'h3, 1'b1, 5'd17, 3'd5, 3'd4, 6'd42, 0);
    @(negedge clk);
    chk("t2_en_pulse", {31'h0, interboard_en}, 32'h1);
    chk("t2_rst_low",  {31'h0, interboard_rst}, 32'h0);
    chk("t2_busy_low", {31'h0, rx_busy}, 32'h0);
    chk_fields(4'h3, 1'b1, 5'd17, 3'd5, 3'd4, 6'd42);
    @(negedge clk);
    chk("t2_en_drop", {31'h0, interboard_en}, 32'h0);
    repeat (2) @(negedge clk);
    chk("t2_en_cnt",  en_cnt - en0, 32'd1);
    chk("t2_rst_cnt", rst_cnt - rst0, 32'd0);

    // Test 3: reset message
    en0 = en_cnt; rst0 = rst_cnt;
    send_frame(4'hF, 1'b1, 5'd0, 3'd0, 3'd0, 6'h15, 0);
    @(negedge clk);
    chk("t3_rst_pulse", {31'h0, interboard_rst}, 32'h1);
    chk("t3_en_low",    {31'h0, interboard_en}, 32'h0);
    @(negedge clk);
    chk("t3_rst_drop",  {31'h0, interboard_rst}, 32'h0);
    repeat (2) @(negedge clk);
    chk("t3_rst_cnt", rst_cnt - rst0, 32'd1);
    chk("t3_en_cnt",  en_cnt - en0, 32'd0);
    chk("t3_msg",     {28'h0, interboard_msg_type}, 32'hF);
    chk("t3_card",    {26'h0, interboard_card}, 32'h15);

    // Test 4: partial frame times out
    en0 = en_cnt;
    send_word(6'h0A, 0);
    send_word(6'h12, 0);
    chk("t4_busy_partial", {31'h0, rx_busy}, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 3 * TMO && !seen; i++) begin
      @(negedge clk);
      if (rx_err) seen = 1'b1;
    end
    chk("t4_err_seen", {31'h0, seen}, 32'h1);
    chk("t4_busy_fall", {31'h0, rx_busy}, 32'h0);
    @(negedge clk);
    chk("t4_err_drop", {31'h0, rx_err}, 32'h0);
    chk("t4_no_en", en_cnt - en0, 32'd0);
    chk_fields(4'hF, 1'b1, 5'd0, 3'd0, 3'd0, 6'h15);

    // Test 4b: next frame aligned; second word's Request held past the timeout
    err0 = err_cnt; en0 = en_cnt;
    send_frame(4'h4, 1'b0, 5'd31, 3'd7, 3'd7, 6'h3F, TMO + 20);
    repeat (3) @(negedge clk);
    chk("t4b_err_cnt", err_cnt - err0, 32'd0);
    chk("t4b_en_cnt",  en_cnt - en0, 32'd1);
    chk_fields(4'h4, 1'b0, 5'd31, 3'd7, 3'd7, 6'h3F);

    // Test 5: reset between W2 and W3
    send_word({4'h2, 1'b1, 1'b0}, 0);
    send_word({5'd9, 1'b0}, 0);
    send_word({3'd1, 3'd2}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ack",  {31'h0, Ack_out}, 32'h0);
    chk("t5_busy", {31'h0, rx_busy}, 32'h0);
    chk("t5_err",  {31'h0, rx_err}, 32'h0);
    chk_fields(4'h0, 1'b0, 5'h00, 3'h0, 3'h0, 6'h00);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    en0 = en_cnt;
    send_frame(4'h5, 1'b1, 5'd12, 3'd3, 3'd6, 6'h2B, 0);
    repeat (3) @(negedge clk);
    chk("t5_en_cnt", en_cnt - en0, 32'd1);
    chk_fields(4'h5, 1'b1, 5'd12, 3'd3, 3'd6, 6'h2B);

`ifdef INTERBOARD_CHECKSUM_EN
    // Test 6: bad check word, then the correct one (0x0E^0x22^0x2C^0x2A = 0x2A)
    en0 = en_cnt; err0 = err_cnt;
    send_word(6'h0E, 0);
    send_word(6'h22, 0);
    send_word(6'h2C, 0);
    send_word(6'h2A, 0);
    send_word(6'h00, 0);
    repeat (3) @(negedge clk);
    chk("t6_bad_err", err_cnt - err0, 32'd1);
    chk("t6_bad_en",  en_cnt - en0, 32'd0);
    chk_fields(4'h5, 1'b1, 5'd12, 3'd3, 3'd6, 6'h2B);
    en0 = en_cnt;
    send_word(6'h0E, 0);
    send_word(6'h22, 0);
    send_word(6'h2C, 0);
    send_word(6'h2A, 0);
    send_word(6'h2A, 0);
    repeat (3) @(negedge clk);
    chk("t6_good_en", en_cnt - en0, 32'd1);
    chk_fields(4'h3, 1'b1, 5'd17, 3'd5, 3'd4, 6'd42);
`endif

    chk("en_rst_overlap", both_cnt, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
